// File: rtl/approx_mul_rr_sched.sv
// rtl/approx_mul_rr_sched.sv - round-robin shared 8x8 approximate/exact multiplier with 2-stage pipeline
//
// approx_mul_core: combinational truncated 8x8 unsigned multiplier.
//    x, y : operands
//    z    : x*y with every partial-product bit of weight below 2**4 dropped
//
// approx_mul_rr_sched: N_REQ requesters share one multiplier.
//    clk, rst                  : clock, asynchronous active-high reset
//    req_valid/req_ready       : per-requester handshake (req_ready one-hot or zero)
//    req_x, req_y              : packed operands, slice i = bits [8i+7:8i]
//    req_exact                 : per-requester mode, 1 = true product, 0 = approximate core
//    rsp_valid/rsp_ready       : response handshake
//    rsp_z, rsp_id, rsp_exact  : product, issuing requester, echoed mode bit
//    busy                      : either pipeline stage occupied

module approx_mul_core (
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   output logic [15:0] z
);
   // Summing shifted partial products and clearing result columns 0..3 of
   // each one removes exactly the bits x[i]&y[j] with i+j < 4.
   always_comb begin
      z = '0;
      for (int j = 0; j < 8; j++) begin
         if (y[j]) begin
            z = z + (({8'b0, x} << j) & 16'hFFF0);
         end
      end
   end
endmodule

module approx_mul_rr_sched #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [8*N_REQ-1:0] req_x,
   input  logic [8*N_REQ-1:0] req_y,
   input  logic [N_REQ-1:0]   req_exact,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [15:0]        rsp_z,
   output logic [ID_W-1:0]    rsp_id,
   output logic               rsp_exact,
   output logic               busy
);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
   localparam logic [ID_W:0]   N_WIDE  = (ID_W + 1)'(N_REQ);

   logic [ID_W-1:0] rr_ptr;

   logic            s1_valid;
   logic [7:0]      s1_x;
   logic [7:0]      s1_y;
   logic [ID_W-1:0] s1_id;
   logic            s1_exact;

   logic            s2_valid;
   logic [15:0]     s2_z;
   logic [ID_W-1:0] s2_id;
   logic            s2_exact;

   logic            adv1;
   logic            adv2;
   logic            grant_any;
   logic [ID_W-1:0] grant_id;
   logic [ID_W:0]   scan;
   logic [7:0]      grant_x;
   logic [7:0]      grant_y;
   logic            grant_exact;
   logic            fire;
   logic [15:0]     approx_z;
   logic [15:0]     exact_z;

   assign adv2 = !s2_valid || rsp_ready;
   assign adv1 = !s1_valid || adv2;

   // Scan from rr_ptr upward, wrapping at N_REQ; first valid requester wins.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      scan      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (ID_W + 1)'(k);
         if (scan >= N_WIDE) begin
            scan = scan - N_WIDE;
         end
         if (!grant_any && req_valid[scan[ID_W-1:0]]) begin
            grant_any = 1'b1;
            grant_id  = scan[ID_W-1:0];
         end
      end
   end

   // Operand mux and ready decode; ready is held low while reset is asserted.
   always_comb begin
      grant_x     = '0;
      grant_y     = '0;
      grant_exact = 1'b0;
      req_ready   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            grant_x      = req_x[8*i +: 8];
            grant_y      = req_y[8*i +: 8];
            grant_exact  = req_exact[i];
            req_ready[i] = grant_any && adv1 && !rst;
         end
      end
   end

   assign fire = |req_ready;

   approx_mul_core u_core (
      .x (s1_x),
      .y (s1_y),
      .z (approx_z)
   );

   assign exact_z = {8'b0, s1_x} * {8'b0, s1_y};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_id    <= '0;
         s1_exact <= 1'b0;
         s2_valid <= 1'b0;
         s2_z     <= '0;
         s2_id    <= '0;
         s2_exact <= 1'b0;
      end else begin
         if (adv2) begin
            s2_valid <= s1_valid;
            s2_z     <= s1_exact ? exact_z : approx_z;
            s2_id    <= s1_id;
            s2_exact <= s1_exact;
         end
         if (adv1) begin
            s1_valid <= grant_any;
            s1_x     <= grant_x;
            s1_y     <= grant_y;
            s1_id    <= grant_id;
            s1_exact <= grant_exact;
         end
         if (fire) begin
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
         end
      end
   end

   assign rsp_valid = s2_valid;
   assign rsp_z     = s2_z;
   assign rsp_id    = s2_id;
   assign rsp_exact = s2_exact;
   assign busy      = s1_valid || s2_valid;
endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// tb/tb_approx_mul_rr_sched.sv - directed self-checking bench for approx_mul_rr_sched
module tb_approx_mul_rr_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_x;
   logic [31:0] req_y;
   logic [3:0]  req_exact;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_z;
   logic [1:0]  rsp_id;
   logic        rsp_exact;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   approx_mul_rr_sched #(.N_REQ(4), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_exact (req_exact),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_z     (rsp_z),
      .rsp_id    (rsp_id),
      .rsp_exact (rsp_exact),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Truncated multiplier reference: keep x[i]*y[j] only when i+j >= 4.
   function automatic logic [15:0] approx_model(input logic [7:0] x, input logic [7:0] y);
      logic [15:0] z;
      z = 16'd0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (x[i] && y[j] && (i + j) >= 4)
               z = z + (16'd1 << (i + j));
      return z;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 4'hF;
      req_x     = '0;
      req_y     = '0;
      req_exact = '0;
      rsp_ready = 1'b1;
      tick();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_exact, rsp_z, busy} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got v=%0b id=%0d ex=%0b z=%0d busy=%0b want all 0", rsp_valid, rsp_id, rsp_exact, rsp_z, busy);
      end
      n_checks++;
      if (req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_req_ready got %b want 0000", req_ready);
      end
      rst       = 1'b0;
      req_valid = 4'h0;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      rsp_ready     = 1'b1;
      req_x[15:8]   = 8'd200;
      req_y[15:8]   = 8'd100;
      req_exact     = 4'b0010;
      req_valid     = 4'b0010;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL single_ready got %b want 0010", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      n_checks++;
      if ({rsp_valid, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL single_stage1 got v=%0b busy=%0b want v=0 busy=1", rsp_valid, busy);
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_exact, rsp_z} !== {1'b1, 2'd1, 1'b1, 16'd20000}) begin
         n_fail++;
         $display("FAIL single_rsp got v=%0b id=%0d ex=%0b z=%0d want v=1 id=1 ex=1 z=20000", rsp_valid, rsp_id, rsp_exact, rsp_z);
      end
      tick();
      n_checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_drain got v=%0b busy=%0b want 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_x[8*i +: 8] = 8'(i + 1);
         req_y[8*i +: 8] = 8'd10;
      end
      req_exact = 4'hF;
      req_valid = 4'hF;
      #1;
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if (req_ready !== 4'(1 << (c % 4))) begin
            n_fail++;
            $display("FAIL rr_grant cycle %0d got %b want %b", c, req_ready, 4'(1 << (c % 4)));
         end
         if (c >= 2) begin
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'((c - 2) % 4), 16'(((c - 2) % 4 + 1) * 10)}) begin
               n_fail++;
               $display("FAIL rr_rsp cycle %0d got v=%0b id=%0d z=%0d want id=%0d z=%0d", c, rsp_valid, rsp_id, rsp_z, (c - 2) % 4, ((c - 2) % 4 + 1) * 10);
            end
         end
         tick();
      end
      req_valid = 4'h0;
      tick();
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_x[8*i +: 8] = 8'(i + 3);
         req_y[8*i +: 8] = 8'd7;
      end
      req_exact = 4'hF;
      req_valid = 4'hF;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL bp_first_ready got %b want 0001", req_ready);
      end
      tick();
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL bp_second_ready got %b want 0010", req_ready);
      end
      tick();
      for (int c = 2; c < 5; c++) begin
         n_checks++;
         if ({req_ready, rsp_valid, rsp_id, rsp_exact, rsp_z} !== {4'b0000, 1'b1, 2'd0, 1'b1, 16'd21}) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d got rdy=%b v=%0b id=%0d z=%0d want rdy=0000 v=1 id=0 z=21", c, req_ready, rsp_valid, rsp_id, rsp_z);
         end
         tick();
      end
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd0, 16'd21}) begin
         n_fail++;
         $display("FAIL bp_drain0 got v=%0b id=%0d z=%0d want v=1 id=0 z=21", rsp_valid, rsp_id, rsp_z);
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd1, 16'd28}) begin
         n_fail++;
         $display("FAIL bp_drain1 got v=%0b id=%0d z=%0d want v=1 id=1 z=28", rsp_valid, rsp_id, rsp_z);
      end
      tick();
      n_checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL bp_empty got v=%0b busy=%0b want 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_approx();
      logic [7:0]  vx[7]  = '{8'd0, 8'd77, 8'd255, 8'd15, 8'd3, 8'd16, 8'd255};
      logic [7:0]  vy[7]  = '{8'd123, 8'd0, 8'd255, 8'd15, 8'd5, 8'd1, 8'd255};
      logic        ve[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [15:0] vz[7]  = '{16'd0, 16'd0, 16'd64976, 16'd176, 16'd0, 16'd16, 16'd65025};
      logic [15:0] exp_q[$];
      logic [15:0] want;
      logic [7:0]  rx;
      logic [7:0]  ry;
      do_reset();
      rsp_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (k < 7) begin
            req_x[7:0]   = vx[k];
            req_y[7:0]   = vy[k];
            req_exact[0] = ve[k];
            req_valid    = 4'b0001;
         end else begin
            req_valid = 4'b0000;
         end
         if (k >= 2) begin
            n_checks++;
            if ({rsp_valid, rsp_exact, rsp_z} !== {1'b1, ve[k-2], vz[k-2]}) begin
               n_fail++;
               $display("FAIL approx_vec %0d got v=%0b ex=%0b z=%0d want ex=%0b z=%0d", k - 2, rsp_valid, rsp_exact, rsp_z, ve[k-2], vz[k-2]);
            end
         end
         tick();
      end
      req_exact[0] = 1'b0;
      for (int k = 0; k < 1002; k++) begin
         if (k < 1000) begin
            rx         = 8'($urandom_range(0, 255));
            ry         = 8'($urandom_range(0, 255));
            req_x[7:0] = rx;
            req_y[7:0] = ry;
            req_valid  = 4'b0001;
            exp_q.push_back(approx_model(rx, ry));
         end else begin
            req_valid = 4'b0000;
         end
         if (k >= 2) begin
            want = exp_q.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_exact, rsp_z} !== {1'b1, 1'b0, want}) begin
               n_fail++;
               $display("FAIL approx_rand %0d got v=%0b ex=%0b z=%0d want z=%0d", k - 2, rsp_valid, rsp_exact, rsp_z, want);
            end
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_x[8*i +: 8] = 8'd50;
         req_y[8*i +: 8] = 8'(i + 1);
      end
      req_exact = 4'hF;
      req_valid = 4'hF;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_exact, rsp_z, busy, req_ready} !== 25'd0) begin
         n_fail++;
         $display("FAIL async_rst_outputs got v=%0b id=%0d ex=%0b z=%0d busy=%0b rdy=%b want all 0", rsp_valid, rsp_id, rsp_exact, rsp_z, busy, req_ready);
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL async_rst_first_grant got %b want 0001", req_ready);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst_stale got v=%0b id=%0d z=%0d want v=0", rsp_valid, rsp_id, rsp_z);
      end
      req_valid = 4'h0;
      tick();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd0, 16'd50}) begin
         n_fail++;
         $display("FAIL async_rst_fresh got v=%0b id=%0d z=%0d want v=1 id=0 z=50", rsp_valid, rsp_id, rsp_z);
      end
      tick();
   endtask

   task automatic test_mixed();
      do_reset();
      rsp_ready     = 1'b1;
      req_x[7:0]    = 8'd9;
      req_y[7:0]    = 8'd9;
      req_x[23:16]  = 8'd15;
      req_y[23:16]  = 8'd15;
      req_exact     = 4'b0001;
      req_valid     = 4'b0101;
      #1;
      for (int c = 0; c < 8; c++) begin
         n_checks++;
         if (req_ready !== ((c % 2 == 0) ? 4'b0001 : 4'b0100)) begin
            n_fail++;
            $display("FAIL mixed_grant cycle %0d got %b", c, req_ready);
         end
         if (c >= 2) begin
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_exact, rsp_z} !==
                ((c % 2 == 0) ? {1'b1, 2'd0, 1'b1, 16'd81} : {1'b1, 2'd2, 1'b0, 16'd176})) begin
               n_fail++;
               $display("FAIL mixed_rsp cycle %0d got v=%0b id=%0d ex=%0b z=%0d", c, rsp_valid, rsp_id, rsp_exact, rsp_z);
            end
         end
         tick();
      end
      req_valid = 4'h0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_approx();
      test_async_reset();
      test_mixed();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/approx_mul_rr_sched.md
Name: approx_mul_rr_sched

Overview:
- Shares one combinational 8x8 unsigned approximate multiplier core among N_REQ requesters.
- Round-robin arbitration selects one requester per cycle; a 2-stage valid/ready pipeline carries operands, then result.
- Results return on one response channel, tagged with the requester ID.
- A per-transaction exact-mode bit bypasses the approximate core with a true x*y product, used for calibration and error measurement.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_x  input  8*N_REQ  packed multiplicand; slice i is bits [8i+7:8i].
- req_y  input  8*N_REQ  packed multiplier, same packing as req_x.
- req_exact  input  N_REQ  per-requester mode bit; 1 = exact product, 0 = approximate core.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_z  output  16  product.
- rsp_id  output  ID_W  index of the requester that issued the product.
- rsp_exact  output  1  echo of the mode bit for this product.
- busy  output  1  high while either pipeline stage holds a transaction.

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_z=0, rsp_id=0, rsp_exact=0, busy=0.
- Reset asserted mid-operation discards all in-flight transactions; no response is produced for them.
- Stage S1 registers: x, y, id, exact, s1_valid.
- Stage S2 registers: z, id, exact, s2_valid. rsp_* are driven directly from S2.
- adv2 = !s2_valid || rsp_ready.
- adv1 = !s1_valid || adv2.
- On adv2: S2 loads S1 contents and s2_valid <= s1_valid. S2 z = exact ? x*y (16-bit, full precision) : approx_core(x, y).
- On adv1: S1 loads the granted request; s1_valid <= (any grant).
- Arbitration is combinational. Search req_valid starting at rr_ptr, ascending, wrapping modulo N_REQ; the first set bit is granted.
- req_ready[g] = adv1 for the granted index g; all other req_ready bits are 0.
- Handshake fires when req_valid[i] && req_ready[i].
- On a fire, rr_ptr <= (g+1) mod N_REQ. With no fire, rr_ptr holds.
- Throughput: 1 product/cycle when rsp_ready is held high. Latency from request fire to rsp_valid is 2 cycles.
- Backpressure: with rsp_ready=0 and both stages full, req_ready is all 0. S2 holds its contents stable; rsp_z, rsp_id and rsp_exact must not change while rsp_valid=1 and rsp_ready=0.
- Simultaneous events: a response accept and a new request fire in the same cycle are both taken; no bubble is inserted.
- Requesters must hold req_x, req_y and req_exact stable while req_valid is high and not yet accepted. The block does not check this.
- Requesters may deassert req_valid before acceptance; the arbiter then skips them without penalty.
- Indices >= N_REQ never exist, so rr_ptr wraps at N_REQ, not at 2**ID_W.
- Approx core: fully combinational, 8-bit x and y in, 16-bit z out, no internal state. It sits between S1 and S2 only.
- busy = s1_valid || s2_valid.
- The exact path uses a native unsigned 8x8 multiply; no truncation.

Test Plan:
- Single request: requester 1 sends x=200, y=100, exact=1 -> rsp_valid 2 cycles after the fire; rsp_z=20000, rsp_id=1, rsp_exact=1.
- Round-robin: all 4 requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0,1,... Each requester receives one grant per 4 cycles; rr_ptr wraps 3->0.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending -> after 2 accepts, req_ready=0 and rsp_* stay frozen. When rsp_ready rises, both products drain in order with no loss or duplication.
- Approx vs golden model: random 1000 operands with exact=0 -> rsp_z matches the bit-accurate model of the core. Corner operands x=0 or y=0 must give z=0; x=255, y=255 with exact=1 must give z=65025.
- Async reset: assert rst while S1 and S2 are full -> all outputs 0 immediately (before the next clock edge). After release, the first grant goes to requester 0 and no stale response appears.
- Mixed mode: interleave exact=1 and exact=0 requests from requesters 0 and 2 -> rsp_exact and rsp_id track each transaction correctly at full throughput.
